instr_fetch_ctrl: RTL
=====================

# instr_fetch_ctrl

Program-sequencing controller for the 2048 x 14-bit instruction ROM. It owns the program counter, drives the ROM address, and registers each returned word into an instruction register for the decoder. It also handles jump, call, return and skip redirects with a one-cycle bubble, and keeps a hardware return-address stack. It sits between the ROM and the core's decode/execute stage.

## Interface
- `STACK_DEPTH`, 8, number of return-address entries (power of two, 2..16).
- `clk` in 1: single system clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hold all state; control inputs are ignored while high.
- `jump_en` in 1: GOTO; load PC from `jump_addr`.
- `call_en` in 1: CALL; push return address, then load PC from `jump_addr`.
- `ret_en` in 1: RETURN; pop the stack into PC.
- `skip_en` in 1: discard the next sequential instruction.
- `jump_addr` in 11: redirect target.
- `Rom_addr_out` out 11: to ROM `Rom_addr_in`; equals the current PC.
- `Rom_data_in` in 14: from ROM `Rom_data_out`; combinational, same cycle.
- `ir` out 14: instruction register.
- `ir_pc` out 11: address of the word held in `ir`.
- `ir_valid` out 1: `ir` holds a real instruction, not a bubble.
- `stack_overflow` out 1: sticky flag, cleared only by `rst`.
- `stack_underflow` out 1: sticky flag, cleared only by `rst`.

## Operation
- Two stages: fetch (PC → ROM, combinational) and IR (registered).
- Normal cycle (`stall`=0, no control): `ir`←`Rom_data_in`, `ir_pc`←PC, `ir_valid`←1, PC←PC+1.
- Control inputs are honoured only when `ir_valid`=1 and `stall`=0. Otherwise they are ignored.
- Priority when several control inputs are asserted: `rst` > `stall` > `ret_en` > `call_en` > `jump_en` > `skip_en`.
- Redirect (`jump`, `call`, `ret`): PC←target, `ir`←NOP (14'h0000), `ir_valid`←0, `ir_pc`←target. The word currently being fetched is discarded. Next cycle fetches the target.
- `call`: push `ir_pc`+1 (mod 2048), then target←`jump_addr`.
- `ret`: target←top of stack; pop.
- `skip`: `ir`←NOP, `ir_valid`←0, PC←PC+1. The fetched word is discarded. `ir_pc` still takes the skipped address.
- Stack: circular buffer with pointer `sp` (mod `STACK_DEPTH`) and occupancy `count` (0..`STACK_DEPTH`).
- Push at `count`=`STACK_DEPTH`: overwrite the oldest entry, keep `count`, set `stack_overflow`.
- Pop at `count`=0: PC←11'h000, `sp` unchanged, set `stack_underflow`.
- PC arithmetic is 11-bit and wraps from 11'h7FF to 11'h000 silently.
- `stall`=1 holds PC, `ir`, `ir_pc`, `ir_valid`, the stack and the flags. `Rom_addr_out` stays at the held PC.

## Timing
- Reset values: PC=0, `Rom_addr_out`=0, `ir`=14'h0000, `ir_pc`=0, `ir_valid`=0, `sp`=0, `count`=0, both flags 0.
- First edge after `rst` falls: `ir`=ROM[0], `ir_pc`=0, `ir_valid`=1, PC=1.
- Fetch latency: one cycle from address to `ir`.
- Redirect penalty: exactly one bubble cycle. The target instruction appears in `ir` two edges after the redirect input is sampled.
- `rst` asserted mid-redirect or mid-stall: reset wins on that edge. Stack contents need not be cleared, but `count` must be.
- Back-to-back redirects are impossible: the bubble forces `ir_valid`=0, so control inputs are ignored for one cycle.

## Structure
- Package `fetch_pkg` holds:
  - `ADDR_W`=11 and `INSTR_W`=14;
  - `NOP_INSTR`=14'h0000;
  - typedefs `addr_t` (logic [10:0]) and `instr_t` (logic [13:0]).
- Sub-module `return_stack` (parameter `STACK_DEPTH`) contains:
  - ports `push`, `pop`, `push_data`, `top`;
  - outputs `overflow_evt` and `underflow_evt`;
  - the `sp`/`count` logic.
- Top level holds the PC, IR, priority mux and sticky flags.

## Test plan
- Reset then free-run, with ROM[0..2]=14'h01A5, 14'h0103, 14'h3007: `ir` shows 01A5/0103/3007 on successive edges, `ir_pc` shows 0/1/2 and `ir_valid`=1 throughout.
- `jump_en` with `jump_addr`=11'h005 while `ir_pc`=2: next edge gives `ir`=0000 and `ir_valid`=0; following edge gives `ir`=ROM[5] and `ir_pc`=5.
- `call_en` to 11'h006 at `ir_pc`=3, then `ret_en` at `ir_pc`=6: PC returns to 11'h004 after one bubble, and `count` returns to 0.
- Nine calls with `STACK_DEPTH`=8: `stack_overflow` is set on the 9th call. Eight returns then yield the addresses of calls 9..2; a further `ret_en` gives PC=0 and sets `stack_underflow`.
- `stall` held 3 cycles with `jump_en` also high: PC, `ir` and `ir_pc` are frozen and the jump is ignored. After release, sequential fetch resumes.
- `skip_en` at `ir_pc`=1: next edge gives `ir_valid`=0 with `ir_pc`=2; following edge gives `ir`=ROM[3]. Also check PC wrap from 11'h7FF to 11'h000.

Source files
------------

// File: rtl/instr_fetch_ctrl_pkg.sv
// rtl/instr_fetch_ctrl_pkg.sv - shared widths, types and redirect selector for the fetch controller
package fetch_pkg;
  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 14;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam instr_t NOP_INSTR = 14'h0000;

  // Which source drives the next PC/IR; ordered by nothing, priority lives in the top.
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_SKIP,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } sel_e;
endpackage

// File: rtl/instr_fetch_ctrl_if.sv
// rtl/instr_fetch_ctrl_if.sv - instruction ROM address/data bus
interface instr_fetch_ctrl_if;
  import fetch_pkg::*;

  addr_t  Rom_addr_out;
  instr_t Rom_data_in;

  modport master (output Rom_addr_out, input Rom_data_in);
  modport slave  (input Rom_addr_out, output Rom_data_in);
endinterface

// File: rtl/instr_fetch_ctrl_return_stack.sv
// rtl/instr_fetch_ctrl_return_stack.sv - circular return-address stack with overflow/underflow events
module return_stack
  import fetch_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push,
  input  logic  pop,
  input  addr_t push_data,
  output addr_t top,
  output logic  overflow_evt,
  output logic  underflow_evt
);
  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;

  addr_t            mem [STACK_DEPTH];
  logic [SP_W-1:0]  sp;
  logic [SP_W-1:0]  sp_prev;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;

  // sp names the next free slot; when full it also names the oldest entry,
  // so a push there overwrites the oldest return address.
  assign sp_prev       = sp - SP_W'(1);
  assign full          = (count == CNT_W'(STACK_DEPTH));
  assign empty         = (count == '0);
  assign top           = empty ? addr_t'(0) : mem[sp_prev];
  assign overflow_evt  = push && full;
  assign underflow_evt = pop && !push && empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      sp    <= '0;
      count <= '0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
      if (!full) count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      sp    <= sp_prev;
      count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[sp] <= push_data;
  end
endmodule

// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - program counter, instruction register and redirect control for the 2048x14 ROM
module instr_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int STACK_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic                jump_en,
  input  logic                call_en,
  input  logic                ret_en,
  input  logic                skip_en,
  input  addr_t               jump_addr,
  instr_fetch_ctrl_if.master  rom,
  output instr_t              ir,
  output addr_t               ir_pc,
  output logic                ir_valid,
  output logic                stack_overflow,
  output logic                stack_underflow
);
  addr_t  pc;
  sel_e   sel;
  addr_t  pc_nxt;
  addr_t  ir_pc_nxt;
  instr_t ir_nxt;
  logic   ir_valid_nxt;
  addr_t  stack_top;
  logic   overflow_evt;
  logic   underflow_evt;

  assign rom.Rom_addr_out = pc;

  // Controls are only meaningful against a real instruction in IR; the bubble
  // after a redirect therefore blocks back-to-back redirects.
  always_comb begin
    sel = SEL_SEQ;
    if (ir_valid && !stall) begin
      if (ret_en)       sel = SEL_RET;
      else if (call_en) sel = SEL_CALL;
      else if (jump_en) sel = SEL_JUMP;
      else if (skip_en) sel = SEL_SKIP;
    end
  end

  always_comb begin
    pc_nxt       = pc + addr_t'(1);
    ir_nxt       = rom.Rom_data_in;
    ir_pc_nxt    = pc;
    ir_valid_nxt = 1'b1;
    unique case (sel)
      SEL_SKIP: begin
        ir_nxt       = NOP_INSTR;
        ir_valid_nxt = 1'b0;
      end
      SEL_JUMP, SEL_CALL: begin
        pc_nxt       = jump_addr;
        ir_nxt       = NOP_INSTR;
        ir_pc_nxt    = jump_addr;
        ir_valid_nxt = 1'b0;
      end
      SEL_RET: begin
        pc_nxt       = stack_top;
        ir_nxt       = NOP_INSTR;
        ir_pc_nxt    = stack_top;
        ir_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  return_stack #(.STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clk           (clk),
    .rst           (rst),
    .push          (sel == SEL_CALL),
    .pop           (sel == SEL_RET),
    .push_data     (ir_pc + addr_t'(1)),
    .top           (stack_top),
    .overflow_evt  (overflow_evt),
    .underflow_evt (underflow_evt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc              <= '0;
      ir              <= NOP_INSTR;
      ir_pc           <= '0;
      ir_valid        <= 1'b0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else if (!stall) begin
      pc              <= pc_nxt;
      ir              <= ir_nxt;
      ir_pc           <= ir_pc_nxt;
      ir_valid        <= ir_valid_nxt;
      stack_overflow  <= stack_overflow | overflow_evt;
      stack_underflow <= stack_underflow | underflow_evt;
    end
  end
endmodule
